// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one BRAM port between two requesters
//
// Purpose:
//   Two requesters (req0 = CPU load/store path, req1 = external I/O agent) share
//   one port of a dual-port BRAM. Only one access is in flight at a time. A
//   request is acknowledged with a one-cycle grant pulse and completed with a
//   one-cycle done pulse. Ties are broken round-robin, so with both requesters
//   continuously asking the grants alternate 0,1,0,1,... and neither starves.
//   Every output comes straight from a register.
//
//   Timing, with the request sampled at edge c:
//     grant + mem signals    visible after edge c
//     write done             visible after edge c+1 (next arbitration edge c+2)
//     read done + rdata      visible after edge c+2 (next arbitration edge c+4)
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 synchronous reset, active low
//   req0/req1           access request, held until the matching grant is seen
//   we0/we1             1 = write, 0 = read (valid while reqN high)
//   addr0/addr1         access address (valid while reqN high)
//   wdata0/wdata1       write data (valid while reqN high)
//   grant0/grant1       1-cycle pulse: request accepted
//   done0/done1         1-cycle pulse: access complete
//   rdata               read data, valid in the done cycle of a read, held otherwise
//   busy                high whenever the FSM is not idle
//   mem_addr/mem_data   BRAM address / write data
//   mem_we              BRAM write enable, high for exactly one cycle per write
//   mem_q               BRAM read data, valid one cycle after the address is sampled

module mem_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_grant0;
  logic                r_grant1;
  logic                r_done0;
  logic                r_done1;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_data;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_last;   // requester granted most recently
  logic                r_owner;  // requester whose access is in flight

  state_t              w_state;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_done0;
  logic                w_done1;
  logic                w_busy;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_data;
  logic                w_mem_we;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_last;
  logic                w_owner;
  logic                w_winner;

  // Sole requester wins; on a tie the one not served last time wins.
  assign w_winner = (req0 && req1) ? ~r_last : req1;

  always_comb begin
    w_state    = r_state;
    w_grant0   = 1'b0;
    w_grant1   = 1'b0;
    w_done0    = 1'b0;
    w_done1    = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_addr = r_mem_addr;
    w_mem_data = r_mem_data;
    w_rdata    = r_rdata;
    w_last     = r_last;
    w_owner    = r_owner;

    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_owner    = w_winner;
          w_last     = w_winner;
          w_mem_addr = w_winner ? addr1  : addr0;
          w_mem_data = w_winner ? wdata1 : wdata0;
          w_mem_we   = w_winner ? we1    : we0;
          w_grant0   = ~w_winner;
          w_grant1   = w_winner;
          w_state    = S_ISSUE;
        end
      end

      // r_mem_we still holds the latched direction of the access here; the
      // default above drops it so the BRAM sees exactly one write cycle.
      S_ISSUE: begin
        if (r_mem_we) begin
          w_done0 = ~r_owner;
          w_done1 = r_owner;
          w_state = S_IDLE;
        end else begin
          w_state = S_WAIT;
        end
      end

      // The BRAM sampled the address at the end of ISSUE, so mem_q is valid now.
      S_WAIT: begin
        w_rdata = mem_q;
        w_done0 = ~r_owner;
        w_done1 = r_owner;
        w_state = S_RESP;
      end

      // done/rdata are visible this cycle; arbitration resumes once back in IDLE.
      S_RESP: begin
        w_state = S_IDLE;
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_grant0   <= 1'b0;
      r_grant1   <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_busy     <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
      r_rdata    <= '0;
      r_last     <= 1'b1;   // requester 0 wins the first tie
      r_owner    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_grant0   <= w_grant0;
      r_grant1   <= w_grant1;
      r_done0    <= w_done0;
      r_done1    <= w_done1;
      r_busy     <= w_busy;
      r_mem_addr <= w_mem_addr;
      r_mem_data <= w_mem_data;
      r_mem_we   <= w_mem_we;
      r_rdata    <= w_rdata;
      r_last     <= w_last;
      r_owner    <= w_owner;
    end
  end

  assign grant0   = r_grant0;
  assign grant1   = r_grant1;
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign busy     = r_busy;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_we   = r_mem_we;
  assign rdata    = r_rdata;

  a_grant_excl: assert property (@(posedge clk) disable iff (!rst) !(r_grant0 && r_grant1));
  a_done_excl:  assert property (@(posedge clk) disable iff (!rst) !(r_done0 && r_done1));
  a_we_issue:   assert property (@(posedge clk) disable iff (!rst) r_mem_we |-> (r_state == S_ISSUE));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          grant0, grant1, done0, done1, busy, mem_we;
  logic [DW-1:0] rdata, mem_data, mem_q;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
  );

  // BRAM port: registered read, one cycle latency
  logic [DW-1:0] bram [0:1023];
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_data;
    mem_q <= bram[mem_addr];
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  op_t q0[$];
  op_t q1[$];

  int n_checks = 0;
  int n_pass   = 0;
  int k        = 0;   // index of the rising edge just taken

  // Reference model: one access at a time, described by its arbitration edge.
  logic [DW-1:0] mem_model [0:1023];
  bit            m_valid = 0;
  int            m_c = 0;
  bit            m_wr = 0;
  bit            m_own = 0;
  bit            m_last = 1;
  int            m_next_arb = 0;
  logic [DW-1:0] m_rdval = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, k, act, exp);
  endtask

  function automatic op_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.addr = a; o.data = d;
    return o;
  endfunction

  // 32 addresses at both ends of the address space
  function automatic logic [AW-1:0] pool(input int i);
    return (i < 16) ? AW'(i) : AW'(1008 + i - 16);
  endfunction

  function automatic op_t rand_op();
    return mk(1'($urandom), pool(int'($urandom_range(0, 31))), DW'($urandom));
  endfunction

  task automatic drive_reqs();
    if (q0.size() > 0) begin
      req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data;
    end else begin
      req0 = 1'b0; we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = DW'($urandom);
    end
    if (q1.size() > 0) begin
      req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data;
    end else begin
      req1 = 1'b0; we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = DW'($urandom);
    end
  endtask

  task automatic model_edge();
    bit w;
    if (!rst) begin
      m_valid = 0; m_last = 1; m_next_arb = k + 1;
      m_rdata = '0; m_addr = '0; m_data = '0;
    end else if (k >= m_next_arb && (req0 || req1)) begin
      w = (req0 && req1) ? !m_last : req1;
      m_valid = 1; m_c = k; m_own = w; m_last = w;
      m_wr   = w ? we1 : we0;
      m_addr = w ? addr1 : addr0;
      m_data = w ? wdata1 : wdata0;
      if (m_wr) begin
        mem_model[m_addr] = m_data;
        m_next_arb = k + 2;
      end else begin
        m_rdval = mem_model[m_addr];
        m_next_arb = k + 4;
      end
    end
    if (m_valid && !m_wr && k == m_c + 2) m_rdata = m_rdval;
  endtask

  task automatic compare();
    bit gnt, dn, bz;
    int done_at, busy_end;
    done_at  = m_wr ? m_c + 1 : m_c + 2;
    busy_end = m_wr ? m_c : m_c + 2;
    gnt = m_valid && (k == m_c);
    dn  = m_valid && (k == done_at);
    bz  = m_valid && (k >= m_c) && (k <= busy_end);
    check("grant0",   32'(grant0),   32'(gnt && !m_own));
    check("grant1",   32'(grant1),   32'(gnt && m_own));
    check("done0",    32'(done0),    32'(dn && !m_own));
    check("done1",    32'(done1),    32'(dn && m_own));
    check("mem_we",   32'(mem_we),   32'(gnt && m_wr));
    check("busy",     32'(busy),     32'(bz));
    check("rdata",    32'(rdata),    32'(m_rdata));
    check("mem_addr", 32'(mem_addr), 32'(m_addr));
    check("mem_data", 32'(mem_data), 32'(m_data));
  endtask

  // One clock: drive, take the edge, update model, check, let requesters see grants.
  task automatic tick();
    drive_reqs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
    if (grant0 && q0.size() > 0) void'(q0.pop_front());
    if (grant1 && q1.size() > 0) void'(q1.pop_front());
    k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n;
    rst = 1'b0;
    drive_reqs();
    @(negedge clk);

    // reset held with req0 pending, then write 0x005 and read it back via req1
    q0.push_back(mk(1'b1, 10'h005, 16'hBEEF));
    run(2);
    rst = 1'b1;
    run(4);
    q1.push_back(mk(1'b0, 10'h005, 16'h0000));
    run(6);

    // both requesters busy from reset: strict alternation
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b1, AW'(16 + i), DW'(16'h1000 + i)));
      q1.push_back(mk(1'b0, 10'h005, 16'h0000));
    end
    tick();
    rst = 1'b1;
    run(24);

    // req1 arrives while req0 read is in WAIT, then 8 alternating accesses
    q0.push_back(mk(1'b0, 10'h005, 16'h0000));
    run(2);
    q1.push_back(mk(1'b0, 10'h011, 16'h0000));
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, AW'(16 + i), 16'h0000));
      q1.push_back(mk(1'b1, AW'(20 + i), DW'($urandom)));
    end
    run(40);

    // reset during ISSUE of a write; afterwards a tie must go to requester 0
    q0.push_back(mk(1'b1, 10'h123, 16'h5A5A));
    n = 0;
    do begin tick(); n++; end while (!grant0 && n < 10);
    check("t5_grant_seen", 32'(grant0), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    q0.push_back(mk(1'b0, 10'h123, 16'h0000));
    q1.push_back(mk(1'b0, 10'h005, 16'h0000));
    run(12);

    // address extremes
    q0.push_back(mk(1'b1, 10'h3FF, 16'h1234));
    q0.push_back(mk(1'b1, 10'h000, 16'hCAFE));
    q1.push_back(mk(1'b0, 10'h3FF, 16'h0000));
    q1.push_back(mk(1'b0, 10'h000, 16'h0000));
    run(20);

    // fill the random address pool, then random traffic with occasional resets
    for (int i = 0; i < 32; i++) q0.push_back(mk(1'b1, pool(i), DW'($urandom)));
    run(70);
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_op());
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_op());
      rst = ($urandom_range(0, 99) != 0);
      tick();
    end
    rst = 1'b1;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
